fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus F/D pipeline latch, directly upstream of control_decode.
//  Owns the PC, drives the synchronous instruction memory and presents {pc+1, instruction, valid}
//  to decode, which slices opcode/rs/rt/rd from fd_instruction. Handles hazard stalls,
//  branch/jump redirects (flush), and keeps fetch/bubble performance counters.
// PARAMETERS
//  IMEM_ADDR_W  12            imem word-address width; PC wraps modulo 2^IMEM_ADDR_W
//  NOP_WORD     32'h00000000  word inserted into F/D on flush (add r0,r0,r0)
//  CNT_W        32            width of performance counters
// PORTS
//  clock            in   1            rising-edge clock
//  reset            in   1            synchronous, active-high
//  stall_f          in   1            hazard unit: hold PC and F/D latch
//  redirect         in   1            taken branch/jump resolved downstream
//  redirect_target  in   32           new PC (word address) when redirect=1
//  imem_addr        out  IMEM_ADDR_W  address to synchronous imem (registered inside imem)
//  imem_data        in   32           imem output; word for address sampled last edge
//  fd_pc_plus1      out  32           PC+1 of instruction in F/D latch
//  fd_instruction   out  32           instruction in F/D latch, consumed by control_decode
//  fd_valid         out  1            F/D holds a real instruction (0 = bubble)
//  fetch_count      out  CNT_W        valid instructions written into F/D (saturating)
//  bubble_count     out  CNT_W        bubbles written into F/D (saturating)
// BEHAVIOUR
//  - Registers: pc_q (32), F/D {pc_plus1, instruction, valid}, two counters. Invariant: after
//    every edge, imem_data is the word at pc_q (imem_addr = pc_next[IMEM_ADDR_W-1:0]).
//  - pc_next priority: reset -> 0; redirect -> redirect_target; stall_f -> pc_q; else pc_q+1.
//    pc_q wraps: pc_q+1 computed in 32 bits, imem_addr uses low IMEM_ADDR_W bits only.
//  - F/D update priority at each edge:
//    reset    : pc_plus1=0, instruction=NOP_WORD, valid=0, counters=0.
//    redirect : instruction=NOP_WORD, valid=0, pc_plus1=0 (flush; overrides stall_f).
//    stall_f  : hold all F/D fields; counters unchanged.
//    else     : pc_plus1=pc_q+1, instruction=imem_data, valid=1.
//  - Latency: address presented at edge N-1 -> word at edge N -> visible on fd_* after edge N+1.
//    After redirect, target instruction appears on fd_* two edges later (one bubble).
//  - Stall: pc_next=pc_q so imem re-reads same word; no instruction lost or duplicated,
//    any stall length. Stall and redirect same cycle: redirect wins.
//  - Back-to-back redirects: each overrides; only last target's word reaches F/D.
//  - Counters: fetch_count +1 on each valid=1 write, bubble_count +1 on each flush write;
//    neither changes on stall or reset-hold; both saturate at all-ones.
//  - Reset mid-operation: all outputs return to reset values at that edge regardless of
//    stall_f/redirect; imem_addr=0 during reset so word 0 is ready on the first free cycle.
//  - Outputs are register-driven except imem_addr (combinational from pc_next).
// STRUCTURE
//  - Shared package: NOP_WORD, IMEM_ADDR_W, opcode field positions [31:27] shared with decode.
//  - One sub-module: fd_latch (enable/flush register bank for {pc_plus1, instruction, valid}).
//  - PC register, next-PC mux and counters live in fetch_stage itself.
// TESTING
//  - Reset then free-run, imem[k]=32'hA000_0000+k: fd_instruction 32'hA0000000, A0000001...
//    on consecutive cycles, fd_pc_plus1 = 1,2,..., fd_valid=1, fetch_count increments each cycle.
//  - stall_f high 3 cycles while fd holds imem[4]: fd_* frozen, imem_addr constant, then imem[5]
//    next; no skip/duplicate; counters unchanged during stall.
//  - redirect=1, target=32'h40 while stall_f=1: next fd_valid=0, fd_instruction=0, bubble_count+1,
//    then fd_instruction=imem[0x40], fd_pc_plus1=0x41.
//  - Redirect on two consecutive cycles (0x10 then 0x20): two bubbles, then imem[0x20]; imem[0x10]
//    never reaches F/D with valid=1.
//  - Run to pc_q=0xFFF (IMEM_ADDR_W=12): imem_addr wraps to 0x000; fd_pc_plus1=0x1000 for imem[0xFFF].
//  - reset asserted mid-stream with redirect=1: fd_valid=0, counters=0, pc_q=0; first release
//    cycle fetches imem[0]; preload counters near all-ones to confirm saturation.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the decode stage that consumes F/D.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned IMEM_ADDR_W_DEFAULT = 12;
    localparam int unsigned CNT_W_DEFAULT       = 32;
    localparam word_t       NOP_WORD_DEFAULT    = 32'h0000_0000;  // add r0,r0,r0

    // Opcode field position, sliced by control_decode from fd_instruction
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input word_t instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fd_latch.sv
// F/D pipeline register bank: reset/flush load a bubble, enable loads a fetched word.
module fd_latch
    import fetch_stage_pkg::*;
#(
    parameter word_t NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic [31:0] d_pc_plus1,
    input  logic [31:0] d_instruction,
    output logic [31:0] q_pc_plus1,
    output logic [31:0] q_instruction,
    output logic        q_valid
);

    // Flush overrides a deasserted enable so a redirect during a stall still bubbles
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            q_pc_plus1    <= '0;
            q_instruction <= NOP_WORD;
            q_valid       <= 1'b0;
        end else if (enable) begin
            q_pc_plus1    <= d_pc_plus1;
            q_instruction <= d_instruction;
            q_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, synchronous imem addressing,
// F/D latch and saturating fetch/bubble counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = IMEM_ADDR_W_DEFAULT,
    parameter word_t       NOP_WORD    = NOP_WORD_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall_f,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_data,
    output logic [31:0]            fd_pc_plus1,
    output logic [31:0]            fd_instruction,
    output logic                   fd_valid,
    output logic [CNT_W-1:0]       fetch_count,
    output logic [CNT_W-1:0]       bubble_count
);

    word_t pc_q;
    word_t pc_next;
    word_t pc_plus1;

    assign pc_plus1 = pc_q + 32'd1;

    always_comb begin
        pc_next = pc_plus1;
        if (reset)
            pc_next = '0;
        else if (redirect)
            pc_next = redirect_target;
        else if (stall_f)
            pc_next = pc_q;
    end

    // imem registers this address, so after each edge imem_data is the word at pc_q
    assign imem_addr = pc_next[IMEM_ADDR_W-1:0];

    always_ff @(posedge clock) begin
        if (reset)
            pc_q <= '0;
        else
            pc_q <= pc_next;
    end

    fd_latch #(
        .NOP_WORD(NOP_WORD)
    ) u_fd_latch (
        .clock        (clock),
        .reset        (reset),
        .enable       (!stall_f),
        .flush        (redirect),
        .d_pc_plus1   (pc_plus1),
        .d_instruction(imem_data),
        .q_pc_plus1   (fd_pc_plus1),
        .q_instruction(fd_instruction),
        .q_valid      (fd_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else if (redirect) begin
            if (bubble_count != '1)
                bubble_count <= bubble_count + CNT_W'(1);
        end else if (!stall_f) begin
            if (fetch_count != '1)
                fetch_count <= fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous imem model where imem[k] = A000_0000 + k.
module tb_fetch_stage;

    localparam int unsigned AW = 12;
    localparam int unsigned CW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall_f;
    logic          redirect;
    logic [31:0]   redirect_target;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   fd_pc_plus1;
    logic [31:0]   fd_instruction;
    logic          fd_valid;
    logic [CW-1:0] fetch_count;
    logic [CW-1:0] bubble_count;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_fetch  = 0;
    int unsigned exp_bubble = 0;

    always #5 clock = ~clock;

    always_ff @(posedge clock)
        imem_data <= 32'hA000_0000 + {20'd0, imem_addr};

    fetch_stage #(
        .IMEM_ADDR_W(AW),
        .NOP_WORD   (32'h0000_0000),
        .CNT_W      (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall_f        (stall_f),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .fd_pc_plus1    (fd_pc_plus1),
        .fd_instruction (fd_instruction),
        .fd_valid       (fd_valid),
        .fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, updating the expected counters from the inputs applied
    task automatic step();
        if (reset) begin
            exp_fetch  = 0;
            exp_bubble = 0;
        end else if (redirect) begin
            if (exp_bubble < 255) exp_bubble++;
        end else if (!stall_f) begin
            if (exp_fetch < 255) exp_fetch++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk_fd(input string tag, input logic [31:0] instr, input logic [31:0] pcp1,
                          input logic valid);
        chk({tag, "_instr"}, fd_instruction, instr);
        chk({tag, "_pcp1"}, fd_pc_plus1, pcp1);
        chk({tag, "_valid"}, {31'd0, fd_valid}, {31'd0, valid});
        chk({tag, "_fetch"}, {24'd0, fetch_count}, exp_fetch);
        chk({tag, "_bubble"}, {24'd0, bubble_count}, exp_bubble);
    endtask

    initial begin
        reset = 1'b1;
        stall_f = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        step();
        step();
        chk_fd("reset", 32'h0, 32'h0, 1'b0);
        chk("reset_addr", {20'd0, imem_addr}, 32'h0);

        // Free run: imem[0..4]
        reset = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            step();
            chk_fd("run", 32'hA000_0000 + k, k + 1, 1'b1);
        end

        // Stall three cycles while F/D holds imem[4]
        stall_f = 1'b1;
        #1;
        chk("stall_addr", {20'd0, imem_addr}, 32'h5);
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            chk_fd("stall", 32'hA000_0004, 32'h5, 1'b1);
            chk("stall_addr_hold", {20'd0, imem_addr}, 32'h5);
        end
        stall_f = 1'b0;
        step();
        chk_fd("post_stall", 32'hA000_0005, 32'h6, 1'b1);
        step();
        chk_fd("post_stall2", 32'hA000_0006, 32'h7, 1'b1);

        // Redirect while stalled: redirect wins
        stall_f = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h40;
        #1;
        chk("redir_addr", {20'd0, imem_addr}, 32'h40);
        step();
        chk_fd("redir_bubble", 32'h0, 32'h0, 1'b0);
        stall_f = 1'b0;
        redirect = 1'b0;
        step();
        chk_fd("redir_target", 32'hA000_0040, 32'h41, 1'b1);

        // Back-to-back redirects: only the second target reaches F/D
        redirect = 1'b1;
        redirect_target = 32'h10;
        step();
        chk_fd("b2b_bubble1", 32'h0, 32'h0, 1'b0);
        redirect_target = 32'h20;
        step();
        chk_fd("b2b_bubble2", 32'h0, 32'h0, 1'b0);
        redirect = 1'b0;
        step();
        chk_fd("b2b_target", 32'hA000_0020, 32'h21, 1'b1);
        step();
        chk_fd("b2b_next", 32'hA000_0021, 32'h22, 1'b1);

        // Address wrap at 0xFFF
        redirect = 1'b1;
        redirect_target = 32'hFF0;
        step();
        redirect = 1'b0;
        for (int unsigned m = 1; m <= 15; m++) begin
            step();
            chk("wrap_run", fd_instruction, 32'hA000_0000 + 32'hFEF + m);
        end
        chk("wrap_addr", {20'd0, imem_addr}, 32'h0);
        step();
        chk_fd("wrap_fff", 32'hA000_0FFF, 32'h1000, 1'b1);
        step();
        chk_fd("wrap_zero", 32'hA000_0000, 32'h1001, 1'b1);

        // Saturation of both counters (CNT_W = 8)
        for (int unsigned k = 0; k < 300; k++) step();
        chk("fetch_sat", {24'd0, fetch_count}, 32'hFF);
        redirect = 1'b1;
        redirect_target = 32'h100;
        for (int unsigned k = 0; k < 260; k++) step();
        chk("bubble_sat", {24'd0, bubble_count}, 32'hFF);
        chk("fetch_sat_hold", {24'd0, fetch_count}, 32'hFF);

        // Reset mid-stream with redirect and stall asserted
        reset = 1'b1;
        stall_f = 1'b1;
        #1;
        chk("rst_addr", {20'd0, imem_addr}, 32'h0);
        step();
        chk_fd("mid_reset", 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        redirect = 1'b0;
        stall_f = 1'b0;
        step();
        chk_fd("after_reset", 32'hA000_0000, 32'h1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
